// File: rtl/hazard_stall_unit_pkg.sv
// Shared constants for the no-forwarding data-hazard detector: register index
// width, hazard vector bit positions and the hard-wired zero register.
package hazard_stall_unit_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int HZ_W       = 4;

  localparam int HZ_SRC1_EM = 0;
  localparam int HZ_SRC1_MW = 1;
  localparam int HZ_SRC2_EM = 2;
  localparam int HZ_SRC2_MW = 3;

  localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

endpackage : hazard_stall_unit_pkg

// File: rtl/hazard_stall_unit_reg_match_cmp.sv
// One source-versus-destination comparator: flags a RAW dependency when the
// consumer reads the register, the producer writes it, and it is not x0.
module reg_match_cmp
  import hazard_stall_unit_pkg::*;
#(
  parameter int W = hazard_stall_unit_pkg::REG_ADDR_W
) (
  input  logic         used_i,
  input  logic         we_i,
  input  logic [W-1:0] src_i,
  input  logic [W-1:0] rd_i,
  output logic         match_o
);

  // x0 is never a real destination, so a write to it cannot create a hazard.
  assign match_o = used_i & we_i & (rd_i != W'(REG_X0)) & (src_i == rd_i);

endmodule : reg_match_cmp

// File: rtl/hazard_stall_unit.sv
// Data-hazard stall generator for the 5-stage pipeline without forwarding,
// with a free-running count of stalled cycles.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int REG_ADDR_W = hazard_stall_unit_pkg::REG_ADDR_W,
  parameter int CNT_W      = 32
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [REG_ADDR_W-1:0] DE_SRC1,
  input  logic [REG_ADDR_W-1:0] DE_SRC2,
  input  logic                  DE_SRC1_USED,
  input  logic                  DE_SRC2_USED,
  input  logic [REG_ADDR_W-1:0] EM_RD,
  input  logic                  EM_WE,
  input  logic [REG_ADDR_W-1:0] MW_RD,
  input  logic                  MW_WE,
  output logic                  STALL_PROCESSOR,
  output logic [HZ_W-1:0]       TYPE,
  output logic [CNT_W-1:0]      STALL_COUNT
);

  logic [HZ_W-1:0]  hz_s;
  logic [CNT_W-1:0] stall_count_d;
  logic [CNT_W-1:0] stall_count_q;

  reg_match_cmp #(.W(REG_ADDR_W)) u_src1_em (
    .used_i(DE_SRC1_USED), .we_i(EM_WE), .src_i(DE_SRC1), .rd_i(EM_RD),
    .match_o(hz_s[HZ_SRC1_EM])
  );

  reg_match_cmp #(.W(REG_ADDR_W)) u_src1_mw (
    .used_i(DE_SRC1_USED), .we_i(MW_WE), .src_i(DE_SRC1), .rd_i(MW_RD),
    .match_o(hz_s[HZ_SRC1_MW])
  );

  reg_match_cmp #(.W(REG_ADDR_W)) u_src2_em (
    .used_i(DE_SRC2_USED), .we_i(EM_WE), .src_i(DE_SRC2), .rd_i(EM_RD),
    .match_o(hz_s[HZ_SRC2_EM])
  );

  reg_match_cmp #(.W(REG_ADDR_W)) u_src2_mw (
    .used_i(DE_SRC2_USED), .we_i(MW_WE), .src_i(DE_SRC2), .rd_i(MW_RD),
    .match_o(hz_s[HZ_SRC2_MW])
  );

  // Stall must act in the same cycle, so these outputs stay combinational.
  assign TYPE            = hz_s;
  assign STALL_PROCESSOR = |hz_s;
  assign STALL_COUNT     = stall_count_q;

  always_comb begin
    stall_count_d = stall_count_q;
    if (STALL_PROCESSOR) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

endmodule : hazard_stall_unit

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: directed cases plus random register
// patterns, expected TYPE/stall/count pushed per driven cycle.
module tb_hazard_stall_unit;

  typedef struct {
    logic [3:0]  typ;
    logic        stall;
    logic [31:0] cnt;
  } exp_t;

  logic        CLK;
  logic        RESET;
  logic [4:0]  DE_SRC1, DE_SRC2, EM_RD, MW_RD;
  logic        DE_SRC1_USED, DE_SRC2_USED, EM_WE, MW_WE;
  logic        STALL_PROCESSOR;
  logic [3:0]  TYPE;
  logic [31:0] STALL_COUNT;

  int          n_checks;
  int          n_fail;
  logic [31:0] cnt_model;
  exp_t        sb_q[$];

  hazard_stall_unit dut (
    .CLK(CLK), .RESET(RESET),
    .DE_SRC1(DE_SRC1), .DE_SRC2(DE_SRC2),
    .DE_SRC1_USED(DE_SRC1_USED), .DE_SRC2_USED(DE_SRC2_USED),
    .EM_RD(EM_RD), .EM_WE(EM_WE), .MW_RD(MW_RD), .MW_WE(MW_WE),
    .STALL_PROCESSOR(STALL_PROCESSOR), .TYPE(TYPE), .STALL_COUNT(STALL_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: hazard when read, written, not x0 and equal.
  function automatic logic [3:0] ref_type(input logic [4:0] s1, input logic [4:0] s2,
                                          input logic u1, input logic u2,
                                          input logic [4:0] erd, input logic ewe,
                                          input logic [4:0] mrd, input logic mwe);
    logic [3:0] t;
    t[0] = (u1 && ewe && erd != 5'd0 && s1 == erd);
    t[1] = (u1 && mwe && mrd != 5'd0 && s1 == mrd);
    t[2] = (u2 && ewe && erd != 5'd0 && s2 == erd);
    t[3] = (u2 && mwe && mrd != 5'd0 && s2 == mrd);
    return t;
  endfunction

  task automatic step(input string tag, input logic rst,
                      input logic [4:0] s1, input logic [4:0] s2,
                      input logic u1, input logic u2,
                      input logic [4:0] erd, input logic ewe,
                      input logic [4:0] mrd, input logic mwe,
                      input logic [3:0] exp_typ);
    exp_t e;
    @(negedge CLK);
    RESET = rst; DE_SRC1 = s1; DE_SRC2 = s2; DE_SRC1_USED = u1; DE_SRC2_USED = u2;
    EM_RD = erd; EM_WE = ewe; MW_RD = mrd; MW_WE = mwe;
    e.typ   = exp_typ;
    e.stall = |exp_typ;
    if (rst) cnt_model = 32'd0;
    else if (e.stall) cnt_model = cnt_model + 32'd1;
    e.cnt = cnt_model;
    sb_q.push_back(e);
    #1;
    e = sb_q.pop_front();
    check_eq({tag, ".type"}, {28'd0, TYPE}, {28'd0, e.typ});
    check_eq({tag, ".stall"}, {31'd0, STALL_PROCESSOR}, {31'd0, e.stall});
    @(posedge CLK);
    #1;
    check_eq({tag, ".count"}, STALL_COUNT, e.cnt);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    cnt_model = 32'd0;
    step("reset0", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 4'b0000);
    step("reset1", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 4'b0000);

    step("no_hazard", 1'b0, 5'd3, 5'd4, 1'b1, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 4'b0000);
    step("em_hz",     1'b0, 5'd5, 5'd4, 1'b1, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 4'b0001);
    step("mw_hz",     1'b0, 5'd5, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 4'b0010);
    step("cleared",   1'b0, 5'd5, 5'd4, 1'b1, 1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 4'b0000);
    check_eq("em_cost_2", STALL_COUNT, 32'd2);

    step("x0_em",     1'b0, 5'd3, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 4'b0000);
    step("mw_we0",    1'b0, 5'd3, 5'd7, 1'b1, 1'b1, 5'd5, 1'b1, 5'd7, 1'b0, 4'b0000);
    step("src2_unused", 1'b0, 5'd3, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 4'b0000);
    step("src2_em",   1'b0, 5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 5'd6, 1'b1, 4'b0100);
    step("src2_mw",   1'b0, 5'd3, 5'd7, 1'b1, 1'b1, 5'd6, 1'b1, 5'd7, 1'b1, 4'b1000);
    step("double",    1'b0, 5'd9, 5'd9, 1'b1, 1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 4'b1111);

    step("rst_a",     1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 4'b0000);
    for (int i = 0; i < 3; i++)
      step("hold", 1'b0, 5'd12, 5'd1, 1'b1, 1'b0, 5'd12, 1'b1, 5'd0, 1'b0, 4'b0001);
    check_eq("hold_3", STALL_COUNT, 32'd3);
    step("rst_b",     1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 4'b0000);
    step("post_rst",  1'b0, 5'd3, 5'd4, 1'b1, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 4'b0000);
    check_eq("post_rst_zero", STALL_COUNT, 32'd0);

    for (int i = 0; i < 60; i++) begin
      logic [4:0] s1, s2, erd, mrd;
      logic u1, u2, ewe, mwe;
      s1  = 5'($urandom_range(0, 3));
      s2  = 5'($urandom_range(0, 3));
      erd = 5'($urandom_range(0, 3));
      mrd = 5'($urandom_range(0, 3));
      u1  = 1'($urandom_range(0, 1));
      u2  = 1'($urandom_range(0, 1));
      ewe = 1'($urandom_range(0, 1));
      mwe = 1'($urandom_range(0, 1));
      step("rand", 1'b0, s1, s2, u1, u2, erd, ewe, mrd, mwe,
           ref_type(s1, s2, u1, u2, erd, ewe, mrd, mwe));
    end

    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_hazard_stall_unit

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
Data-hazard detection block for the 5-stage RISC-V pipeline, which has no forwarding paths.
- Compares the register sources of the instruction in the Decode/Execute (DE) latch against the destinations of the instructions in the Execute/Memory (EM) and Memory/Writeback (MW) latches.
- Raises a stall request to the pipeline control and reports which hazard fired.
- Keeps a registered count of stall cycles for performance monitoring.

Parameters:
- REG_ADDR_W, 5, register-index width.
- CNT_W, 32, stall-cycle counter width.

Ports:
- CLK  in  1  system clock; all registers update on the rising edge.
- RESET  in  1  reset, synchronous, active-high.
- DE_SRC1  in  5  rs1 of the DE instruction (IR[19:15]).
- DE_SRC2  in  5  rs2 of the DE instruction (IR[24:20]).
- DE_SRC1_USED  in  1  DE instruction actually reads rs1.
- DE_SRC2_USED  in  1  DE instruction actually reads rs2.
- EM_RD  in  5  rd of the EM instruction (IR[11:7]).
- EM_WE  in  1  EM instruction writes the register file.
- MW_RD  in  5  rd of the MW instruction (IR[11:7]).
- MW_WE  in  1  MW instruction writes the register file.
- STALL_PROCESSOR  out  1  hold PC/FD/DE and insert a bubble into EM.
- TYPE  out  4  hazard vector; bit0 = SRC1~EM, bit1 = SRC1~MW, bit2 = SRC2~EM, bit3 = SRC2~MW.
- STALL_COUNT  out  32  number of cycles so far in which STALL_PROCESSOR was 1.

Behaviour:
- Match definitions (combinational):
  - m1e = DE_SRC1_USED & EM_WE & (EM_RD != 0) & (DE_SRC1 == EM_RD)
  - m1m, m2e, m2m defined the same way for the other source/stage pairs.
- x0 never causes a hazard, even when writes are enabled.
- TYPE = {m2m, m2e, m1m, m1e}.
- STALL_PROCESSOR = |TYPE. Fully combinational, zero latency: it changes in the same cycle the inputs change.
- Both EM and MW matching the same source is a legal case: both bits are set and the stall is asserted.
- Multi-cycle stalls arise naturally from the surrounding pipeline:
  - The pipeline holds DE and inserts a bubble into EM (EM_WE = 0).
  - An EM hazard therefore becomes an MW hazard the next cycle, then clears.
  - Result: an EM-distance dependency costs 2 stall cycles, an MW-distance dependency costs 1.
- Writeback is assumed to write in the first half-cycle (register-file write-before-read), so no WB-stage comparison is needed.
- STALL_COUNT:
  - On a rising edge with RESET = 1, it is set to 0.
  - Otherwise, when STALL_PROCESSOR = 1, it increments by 1.
  - It wraps modulo 2^CNT_W.
- Reset has no effect on the combinational outputs. STALL_PROCESSOR and TYPE follow the inputs during reset. Upstream must drive the *_WE inputs to 0 while RESET is high, so the stall is 0 during reset.
- Unknown (X) inputs are not specially handled.
- No other state.

Decomposition:
- Shared package: REG_ADDR_W; the TYPE bit indices (HZ_SRC1_EM = 0, HZ_SRC1_MW = 1, HZ_SRC2_EM = 2, HZ_SRC2_MW = 3); the x0 constant.
- One sub-module: reg_match_cmp, which computes (used & we & rd != 0 & src == rd). It is instantiated 4 times.
- The counter stays inline.

Test Plan:
- No hazard: DE_SRC1 = 3, DE_SRC2 = 4, EM_RD = 5, MW_RD = 6, all used/WE = 1 -> STALL_PROCESSOR = 0, TYPE = 4'b0000.
- EM hazard: DE_SRC1 = 5, EM_RD = 5, EM_WE = 1 -> STALL_PROCESSOR = 1, TYPE = 4'b0001. Next cycle, with EM_RD now in MW (MW_RD = 5) and EM_WE = 0 -> TYPE = 4'b0010. Then clear -> STALL_COUNT advanced by 2.
- x0 and disable filtering:
  - DE_SRC2 = 0, EM_RD = 0, EM_WE = 1 -> no stall.
  - DE_SRC2 = 7, MW_RD = 7, MW_WE = 0 -> no stall.
  - DE_SRC2_USED = 0 with a matching rd -> no stall.
- Double match: DE_SRC1 = DE_SRC2 = 9, EM_RD = MW_RD = 9, both WE = 1 -> TYPE = 4'b1111, STALL_PROCESSOR = 1.
- Reset: hold a stall for 3 cycles -> STALL_COUNT = 3. Assert RESET for 1 cycle -> STALL_COUNT = 0 on the following edge. Deassert with no hazard -> STALL_COUNT remains 0.
